// File: rtl/array2_tuple_fifo_if.sv
// rtl/array2_tuple_fifo_if.sv - ready/valid bundle for the 4-element tuple-array FIFO
interface array2_tuple_fifo_if #(
    parameter int DEPTH = 2,
    parameter int W1    = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          I_0__0, I_1__0, I_2__0, I_3__0;
    logic [W1-1:0] I_0__1, I_1__1, I_2__1, I_3__1;
    logic          I_valid;
    logic          I_ready;
    logic          O_0__0, O_1__0, O_2__0, O_3__0;
    logic [W1-1:0] O_0__1, O_1__1, O_2__1, O_3__1;
    logic          O_valid;
    logic          O_ready;
    logic [CW-1:0] COUNT;

    modport slave (
        input  I_0__0, I_1__0, I_2__0, I_3__0,
        input  I_0__1, I_1__1, I_2__1, I_3__1,
        input  I_valid, O_ready,
        output I_ready, O_valid, COUNT,
        output O_0__0, O_1__0, O_2__0, O_3__0,
        output O_0__1, O_1__1, O_2__1, O_3__1
    );

    modport master (
        output I_0__0, I_1__0, I_2__0, I_3__0,
        output I_0__1, I_1__1, I_2__1, I_3__1,
        output I_valid, O_ready,
        input  I_ready, O_valid, COUNT,
        input  O_0__0, O_1__0, O_2__0, O_3__0,
        input  O_0__1, O_1__1, O_2__1, O_3__1
    );
endinterface

// File: rtl/array2_tuple_fifo.sv
// rtl/array2_tuple_fifo.sv - circular FIFO of 4-element tuple arrays ahead of the permutation stage
module array2_tuple_fifo #(
    parameter int DEPTH = 2,
    parameter int W1    = 2
) (
    input  logic                  CLK,
    input  logic                  ASYNCRESETN,
    array2_tuple_fifo_if.slave    bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = 1 + W1;
    localparam int WW = 4 * EW;

    logic [WW-1:0] mem_q [DEPTH];
    logic [WW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [WW-1:0] in_word;
    logic [WW-1:0] head_word;
    logic          push;
    logic          pop;

    // Element k occupies bits [k*EW +: EW], field 0 in the LSB.
    assign in_word = {bus.I_3__1, bus.I_3__0, bus.I_2__1, bus.I_2__0,
                      bus.I_1__1, bus.I_1__0, bus.I_0__1, bus.I_0__0};

    assign head_word = mem_q[rd_ptr_q];
    assign {bus.O_3__1, bus.O_3__0, bus.O_2__1, bus.O_2__0,
            bus.O_1__1, bus.O_1__0, bus.O_0__1, bus.O_0__0} = head_word;

    // Ready depends only on stored count, so a full FIFO refuses a push even on a pop cycle.
    assign bus.I_ready = (count_q != CW'(DEPTH));
    assign bus.O_valid = (count_q != '0);
    assign bus.COUNT   = count_q;

    assign push = bus.I_valid & bus.I_ready;
    assign pop  = bus.O_valid & bus.O_ready;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_word;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_array2_tuple_fifo.sv
// tb/tb_array2_tuple_fifo.sv - directed and random checks of array2_tuple_fifo against a queue model
module tb_array2_tuple_fifo;
    localparam int DEPTH = 2;
    localparam int W1    = 2;

    logic CLK;
    logic ASYNCRESETN;
    int   checks = 0;
    int   errors = 0;

    logic [11:0] model_q[$];

    array2_tuple_fifo_if #(.DEPTH(DEPTH), .W1(W1)) bus ();

    array2_tuple_fifo #(.DEPTH(DEPTH), .W1(W1)) dut (
        .CLK        (CLK),
        .ASYNCRESETN(ASYNCRESETN),
        .bus        (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [11:0] w);
        {bus.I_3__1, bus.I_3__0, bus.I_2__1, bus.I_2__0,
         bus.I_1__1, bus.I_1__0, bus.I_0__1, bus.I_0__0} = w;
    endtask

    function automatic logic [11:0] get_out();
        return {bus.O_3__1, bus.O_3__0, bus.O_2__1, bus.O_2__0,
                bus.O_1__1, bus.O_1__0, bus.O_0__1, bus.O_0__0};
    endfunction

    // Element k = {field1, field0}, 3 bits each, element 0 lowest.
    function automatic logic [11:0] mk(input logic [1:0] f1 [4], input logic f0 [4]);
        logic [11:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) w[k*3 +: 3] = {f1[k], f0[k]};
        return w;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".O_valid"}, 32'(bus.O_valid), 32'(model_q.size() != 0));
        chk({tag, ".I_ready"}, 32'(bus.I_ready), 32'(model_q.size() != DEPTH));
        chk({tag, ".COUNT"},   32'(bus.COUNT),   32'(model_q.size()));
        if (model_q.size() != 0) chk({tag, ".data"}, 32'(get_out()), 32'(model_q[0]));
    endtask

    // Called near the falling edge: drive, check registered state, advance one cycle.
    task automatic tick(input string tag, input bit iv, input logic [11:0] w, input bit ordy);
        bit do_push, do_pop;
        bus.I_valid = iv;
        bus.O_ready = ordy;
        set_in(w);
        #1;
        check_state(tag);
        do_push = iv && (model_q.size() < DEPTH);
        do_pop  = ordy && (model_q.size() > 0);
        @(posedge CLK);
        #1;
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(w);
        @(negedge CLK);
    endtask

    task automatic async_reset(input string tag);
        #2;
        ASYNCRESETN = 1'b0;
        #1;
        model_q.delete();
        check_state(tag);
        chk({tag, ".O_zero"}, 32'(get_out()), 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        #2;
        ASYNCRESETN = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        logic [1:0]  f1 [4];
        logic        f0 [4];
        logic [11:0] wa, wb, wc, w;

        ASYNCRESETN  = 1'b1;
        bus.I_valid  = 1'b0;
        bus.O_ready  = 1'b0;
        set_in('0);
        @(negedge CLK);

        // Reset asserted mid-cycle, checked before any clock edge.
        async_reset("reset");

        // Single word: element k = {k, k[0]}.
        for (int k = 0; k < 4; k++) begin
            f1[k] = 2'(k);
            f0[k] = 1'(k & 1);
        end
        w = mk(f1, f0);
        tick("single_push", 1'b1, w, 1'b1);
        chk("single.O_1__1", 32'(bus.O_1__1), 32'd1);
        chk("single.O_3__0", 32'(bus.O_3__0), 32'd1);
        chk("single.O_3__1", 32'(bus.O_3__1), 32'd3);
        tick("single_pop", 1'b0, '0, 1'b1);
        tick("single_empty", 1'b0, '0, 1'b1);

        // Fill, then overflow attempt with head held.
        wa = 12'hA5C; wb = 12'h3B6; wc = 12'h7E1;
        tick("fill_a", 1'b1, wa, 1'b0);
        tick("fill_b", 1'b1, wb, 1'b0);
        tick("fill_over", 1'b1, wc, 1'b0);
        chk("fill.head_held", 32'(get_out()), 32'(wa));
        // Full with a pop in the same cycle: push still refused.
        tick("full_pushpop", 1'b1, wc, 1'b1);
        tick("drain_b", 1'b0, '0, 1'b1);
        tick("drain_end", 1'b0, '0, 1'b1);

        // Drain order from full.
        tick("refill_a", 1'b1, wa, 1'b0);
        tick("refill_b", 1'b1, wb, 1'b0);
        tick("drain1", 1'b0, '0, 1'b1);
        tick("drain2", 1'b0, '0, 1'b1);
        tick("drain3", 1'b0, '0, 1'b1);

        // Streaming with pointer wrap.
        for (int i = 0; i < 17; i++) tick("stream", 1'b1, 12'(i + 1), 1'b1);
        tick("stream_tail", 1'b0, '0, 1'b1);
        tick("stream_empty", 1'b0, '0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++)
            tick("rand", 1'($urandom_range(0, 1)), 12'($urandom), 1'($urandom_range(0, 1)));

        // Reset with COUNT=2 discards contents.
        while (model_q.size() < DEPTH) tick("prefill", 1'b1, 12'($urandom), 1'b0);
        tick("full_before_reset", 1'b0, '0, 1'b0);
        async_reset("reset_full");
        tick("post_reset_push", 1'b1, wc, 1'b0);
        tick("post_reset_head", 1'b0, '0, 1'b0);
        chk("post_reset.data", 32'(get_out()), 32'(wc));
        tick("post_reset_pop", 1'b0, '0, 1'b1);
        tick("post_reset_empty", 1'b0, '0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
